sp_memory_scrub_ctrl: RTL and testbench
=======================================

# sp_memory_scrub_ctrl

Background ECC scrub controller and port arbiter for `sp_memory` instances built with `ECC=1`. It sits between the AHB wrapper's memory request bus and the memory core. It walks the array one word per scrub interval using only cycles the bus leaves idle, and writes back corrected data on single-bit errors. It counts and logs uncorrectable errors, and the bus is never stalled by it.

## Interface
- `WIDTH`, default 32: data width; must match the core.
- `DEPTH`, default 1024: words in the core.
- `PIPELINE`, default 0: core read latency is 1 + PIPELINE cycles (READ_LAT).
- `INTERVAL`, default 1024: cycles between scrub steps; must be ≥ 2.
- `CNT_W`, default 16: width of the error counters.

Ports:
- `hclk  in  1`: clock.
- `hresetn  in  1`: reset, asynchronous, active-low.
- `scrub_en  in  1`: enable scrubbing.
- `bus_cs`, `bus_we`  in  1: bus-side request from the AHB wrapper.
- `bus_addr  in  $clog2(DEPTH)`, `bus_wdata  in  WIDTH`, `bus_wstrb  in  WIDTH/8`: bus-side request fields.
- `mem_cs`, `mem_we  out  1`; `mem_addr`, `mem_wdata`, `mem_wstrb  out`: request to the core, same widths as the bus side.
- `mem_rdata  in  WIDTH`: core read data, already corrected on a single-bit error.
- `err_ecc_single`, `err_ecc_double  in  1`: core flags, aligned with `mem_rdata`.
- `scrub_addr  out  $clog2(DEPTH)`: next word to scrub.
- `corr_count`, `uncorr_count  out  CNT_W`: saturating error counters.
- `last_uncorr_addr  out  $clog2(DEPTH)`: address of the most recent double error.
- `uncorr_irq  out  1`: 1-cycle pulse per double error.
- `pass_done  out  1`: 1-cycle pulse when a full sweep completes.

## Operation
- Arbitration is combinational. When `bus_cs` = 1, all `mem_*` outputs equal the `bus_*` inputs, unconditionally. Otherwise the scrubber drives `mem_*`, which are 0 when the scrubber is not issuing.
- FSM states are IDLE, READ, WAIT, WBACK.
- IDLE:
  - The timer loads INTERVAL−1 on entry and decrements each cycle while `scrub_en` = 1.
  - It holds while `scrub_en` = 0.
  - At 0 with `scrub_en` = 1, go to READ.
- READ: while `bus_cs` = 1, wait with no access. In the first cycle with `bus_cs` = 0, issue a read of `scrub_addr` (`mem_cs` = 1, `mem_we` = 0), then go to WAIT.
- WAIT:
  - Sample the error flags and `mem_rdata` exactly READ_LAT cycles after the issue.
  - Bus accesses during WAIT are allowed; their responses arrive in later cycles and are ignored.
  - Single error: increment `corr_count`, capture the data, go to WBACK.
  - Double error: increment `uncorr_count`, set `last_uncorr_addr` = `scrub_addr`, pulse `uncorr_irq`, advance, go to IDLE.
  - Clean read: advance, go to IDLE.
- WBACK: in the first cycle with `bus_cs` = 0, write the captured data (`mem_we` = 1, `wstrb` all ones), advance, go to IDLE.
- Write-back abort: a bus write (`bus_cs & bus_we`) to `scrub_addr` at any time between the scrub read issue and the write-back cancels the write-back. The bus data is newer. Advance and go to IDLE; `corr_count` is still incremented.
- Advance: `scrub_addr` increments. DEPTH−1 wraps to 0 and pulses `pass_done` in the same cycle.
- Counters saturate at all-ones.
- Deasserting `scrub_en` does not abort a step in progress. The current READ/WAIT/WBACK step completes; the next IDLE then holds its timer.

## Timing
- Reset values: all registered outputs are 0; `scrub_addr` = 0; the timer holds INTERVAL−1; state is IDLE; `mem_*` pass the bus through.
- If `scrub_en` is high from reset and the bus is idle:
  - FSM enters READ at cycle INTERVAL and the read issues that cycle.
  - Flags are sampled at INTERVAL+READ_LAT.
  - A write-back, if needed, issues at INTERVAL+READ_LAT+1.
- Step period with an idle bus:
  - INTERVAL+READ_LAT+1 cycles for a clean step.
  - INTERVAL+READ_LAT+2 cycles for a step with write-back.
- Each bus-busy cycle during READ or WBACK adds one cycle.
- `uncorr_irq` and `pass_done` are registered and high for exactly 1 cycle.

## Structure
- Package `sp_memory_scrub_pkg` holds:
  - the `scrub_state_e` enum;
  - a `read_lat(PIPELINE)` function;
  - a `sat_inc` function for the saturating counters.
- No sub-module. The single FSM, timer, and output mux fit in one module.

## Test plan
All scenarios use DEPTH = 16, INTERVAL = 8, PIPELINE = 0, with the real ECC core.
- **Clean sweep:** clean memory, `scrub_en` = 1, bus idle → reads of addresses 0..15 issued 10 cycles apart; `pass_done` pulses once after the read of 15; both counters stay 0.
- **Single error:** backdoor flip of one bit at address 5 → one write of the corrected word to 5; `corr_count` = 1; a later bus read of 5 shows `err_ecc_single` = 0.
- **Double error:** two bits flipped at address 9 → `uncorr_count` = 1, `last_uncorr_addr` = 9, `uncorr_irq` high for 1 cycle, no write to 9.
- **Contention:** `bus_cs` held high for 20 cycles when READ is due → `mem_*` equals `bus_*` in every one of those cycles; the scrub read issues in the first cycle `bus_cs` = 0.
- **Write-back race:** single error at 3, bus writes 0xDEADBEEF to 3 during WAIT → no scrub write occurs; address 3 reads back 0xDEADBEEF; `corr_count` = 1.
- **Reset mid-WBACK:** assert `hresetn` low while in WBACK → outputs return to reset values immediately; after release, scrubbing restarts at address 0.

Source files
------------

// File: rtl/sp_memory_scrub_pkg.sv
// Shared types and helpers for the sp_memory ECC scrub controller.
// Holds the FSM state enum, read-latency and saturating-increment helpers.
package sp_memory_scrub_pkg;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WAIT,
    WBACK
  } scrub_state_e;

  function automatic int read_lat(input int pipeline);
    return 1 + pipeline;
  endfunction

  function automatic logic [63:0] sat_inc(
    input logic [63:0] v,
    input int          w
  );
    logic [63:0] top;
    top = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    return (v == top) ? v : v + 64'd1;
  endfunction

endpackage

// File: rtl/sp_memory_scrub_ctrl.sv
// Background ECC scrubber and bus/scrub arbiter for an sp_memory core.
// Scrub accesses only use idle bus cycles; the bus always wins the port.
module sp_memory_scrub_ctrl
  import sp_memory_scrub_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 1024,
  parameter int PIPELINE = 0,
  parameter int INTERVAL = 1024,
  parameter int CNT_W    = 16,
  localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int SW      = WIDTH / 8
) (
  input  logic             hclk,
  input  logic             hresetn,
  input  logic             scrub_en,
  input  logic             bus_cs,
  input  logic             bus_we,
  input  logic [AW-1:0]    bus_addr,
  input  logic [WIDTH-1:0] bus_wdata,
  input  logic [SW-1:0]    bus_wstrb,
  output logic             mem_cs,
  output logic             mem_we,
  output logic [AW-1:0]    mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic [SW-1:0]    mem_wstrb,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             err_ecc_single,
  input  logic             err_ecc_double,
  output logic [AW-1:0]    scrub_addr,
  output logic [CNT_W-1:0] corr_count,
  output logic [CNT_W-1:0] uncorr_count,
  output logic [AW-1:0]    last_uncorr_addr,
  output logic             uncorr_irq,
  output logic             pass_done
);

  localparam int RL = read_lat(PIPELINE);
  localparam int TW = $clog2(INTERVAL);
  localparam int LW = $clog2(RL + 1);
  localparam logic [TW-1:0] T_LOAD = TW'(INTERVAL - 1);
  localparam logic [LW-1:0] L_LOAD = LW'(RL - 1);
  localparam logic [AW-1:0] A_LAST = AW'(DEPTH - 1);

  scrub_state_e     state;
  logic [TW-1:0]    timer;
  logic [LW-1:0]    lat;
  logic [WIDTH-1:0] cap;
  logic             abort_q;

  logic hit;
  logic abort_now;
  logic sample;
  logic adv;
  logic wrap;

  assign hit       = bus_cs & bus_we & (bus_addr == scrub_addr);
  assign abort_now = abort_q | hit;
  assign sample    = (state == WAIT) & (lat == '0);
  assign wrap      = (scrub_addr == A_LAST);

  // A step retires on a clean/double/aborted sample or a done write-back.
  always_comb begin
    adv = 1'b0;
    if (sample)
      adv = err_ecc_double | ~err_ecc_single | abort_now;
    else if (state == WBACK)
      adv = ~bus_cs | hit;
  end

  always_comb begin
    mem_cs    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    if (bus_cs) begin
      mem_cs    = 1'b1;
      mem_we    = bus_we;
      mem_addr  = bus_addr;
      mem_wdata = bus_wdata;
      mem_wstrb = bus_wstrb;
    end else if (state == READ) begin
      mem_cs   = 1'b1;
      mem_addr = scrub_addr;
    end else if (state == WBACK) begin
      mem_cs    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = scrub_addr;
      mem_wdata = cap;
      mem_wstrb = '1;
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state            <= IDLE;
      timer            <= T_LOAD;
      lat              <= '0;
      cap              <= '0;
      abort_q          <= 1'b0;
      scrub_addr       <= '0;
      corr_count       <= '0;
      uncorr_count     <= '0;
      last_uncorr_addr <= '0;
      uncorr_irq       <= 1'b0;
      pass_done        <= 1'b0;
    end else begin
      uncorr_irq <= 1'b0;
      pass_done  <= 1'b0;
      if (sample && err_ecc_double) begin
        uncorr_count     <= CNT_W'(sat_inc(64'(uncorr_count), CNT_W));
        last_uncorr_addr <= scrub_addr;
        uncorr_irq       <= 1'b1;
      end else if (sample && err_ecc_single) begin
        corr_count <= CNT_W'(sat_inc(64'(corr_count), CNT_W));
        cap        <= mem_rdata;
      end
      if (adv) begin
        state      <= IDLE;
        timer      <= T_LOAD;
        scrub_addr <= wrap ? '0 : scrub_addr + 1'b1;
        pass_done  <= wrap;
      end else begin
        unique case (state)
          IDLE: begin
            if (scrub_en) begin
              if (timer == '0) state <= READ;
              else             timer <= timer - 1'b1;
            end
          end
          READ: begin
            if (!bus_cs) begin
              state   <= WAIT;
              lat     <= L_LOAD;
              abort_q <= 1'b0;
            end
          end
          WAIT: begin
            if (sample) begin
              state <= WBACK;
            end else begin
              lat     <= lat - 1'b1;
              abort_q <= abort_now;
            end
          end
          WBACK: state <= WBACK;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sp_memory_scrub_ctrl.sv
// Randomized directed bench for sp_memory_scrub_ctrl with a behavioural
// ECC memory stand-in and an arithmetic schedule model.
module tb_sp_memory_scrub_ctrl;

  localparam int WIDTH    = 32;
  localparam int DEPTH    = 16;
  localparam int PIPELINE = 0;
  localparam int INTERVAL = 8;
  localparam int CNT_W    = 16;
  localparam int AW       = 4;
  localparam int SW       = 4;
  localparam int RL       = 1 + PIPELINE;
  localparam int STEP     = INTERVAL + RL + 1;

  typedef struct {
    int               cyc;
    logic             we;
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] data;
    logic [SW-1:0]    strb;
  } acc_t;

  logic             hclk = 1'b0;
  logic             hresetn = 1'b0;
  logic             scrub_en = 1'b0;
  logic             bus_cs = 1'b0;
  logic             bus_we = 1'b0;
  logic [AW-1:0]    bus_addr = '0;
  logic [WIDTH-1:0] bus_wdata = '0;
  logic [SW-1:0]    bus_wstrb = '0;
  logic             mem_cs;
  logic             mem_we;
  logic [AW-1:0]    mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic [SW-1:0]    mem_wstrb;
  logic [WIDTH-1:0] mem_rdata;
  logic             err_ecc_single;
  logic             err_ecc_double;
  logic [AW-1:0]    scrub_addr;
  logic [CNT_W-1:0] corr_count;
  logic [CNT_W-1:0] uncorr_count;
  logic [AW-1:0]    last_uncorr_addr;
  logic             uncorr_irq;
  logic             pass_done;

  logic             bd_en = 1'b0;
  logic [AW-1:0]    bd_addr = '0;
  logic [WIDTH-1:0] bd_data = '0;
  logic [1:0]       bd_err = '0;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [1:0]       err [DEPTH];
  logic [WIDTH-1:0] exp_mem [DEPTH];

  int   cyc;
  int   checks = 0;
  int   errs = 0;
  acc_t log_q[$];
  acc_t sel_q[$];
  int   pass_q[$];
  int   irq_q[$];

  sp_memory_scrub_ctrl #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .PIPELINE(PIPELINE),
    .INTERVAL(INTERVAL), .CNT_W(CNT_W)
  ) dut (
    .hclk(hclk), .hresetn(hresetn), .scrub_en(scrub_en),
    .bus_cs(bus_cs), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata), .err_ecc_single(err_ecc_single),
    .err_ecc_double(err_ecc_double), .scrub_addr(scrub_addr),
    .corr_count(corr_count), .uncorr_count(uncorr_count),
    .last_uncorr_addr(last_uncorr_addr), .uncorr_irq(uncorr_irq),
    .pass_done(pass_done)
  );

  always #5 hclk = ~hclk;

  always @(posedge hclk or negedge hresetn)
    if (!hresetn) cyc <= 0;
    else          cyc <= cyc + 1;

  // ECC core stand-in: err[] counts flipped bits; reads return corrected data
  always @(posedge hclk) begin
    err_ecc_single <= 1'b0;
    err_ecc_double <= 1'b0;
    if (bd_en) begin
      mem[bd_addr] <= bd_data;
      err[bd_addr] <= bd_err;
    end else if (mem_cs && mem_we) begin
      for (int b = 0; b < SW; b++)
        if (mem_wstrb[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      err[mem_addr] <= 2'd0;
    end else if (mem_cs) begin
      mem_rdata      <= mem[mem_addr];
      err_ecc_single <= (err[mem_addr] == 2'd1);
      err_ecc_double <= (err[mem_addr] == 2'd2);
    end
  end

  always @(negedge hclk) begin
    if (hresetn) begin
      if (mem_cs && !bus_cs)
        log_q.push_back(acc_t'{cyc, mem_we, mem_addr, mem_wdata, mem_wstrb});
      if (pass_done)  pass_q.push_back(cyc);
      if (uncorr_irq) irq_q.push_back(cyc);
    end
  end

  function automatic int exp_read_cyc(input int idx, input int wb_idx);
    int t;
    t = INTERVAL;
    for (int s = 0; s < idx; s++) t += STEP + ((s == wb_idx) ? 1 : 0);
    return t;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic bus_idle();
    bus_cs    = 1'b0;
    bus_we    = 1'b0;
    bus_addr  = '0;
    bus_wdata = '0;
    bus_wstrb = '0;
  endtask

  task automatic reset_init();
    hresetn  = 1'b0;
    scrub_en = 1'b0;
    bus_idle();
    for (int i = 0; i < DEPTH; i++) begin
      tick();
      bd_en      = 1'b1;
      bd_addr    = AW'(i);
      bd_data    = $urandom;
      bd_err     = 2'd0;
      exp_mem[i] = bd_data;
    end
    tick();
    bd_en = 1'b0;
  endtask

  task automatic inject(input int a, input int nbits);
    tick();
    bd_en   = 1'b1;
    bd_addr = AW'(a);
    bd_data = exp_mem[a];
    bd_err  = 2'(nbits);
    tick();
    bd_en = 1'b0;
  endtask

  task automatic release_rst();
    tick();
    hresetn  = 1'b1;
    scrub_en = 1'b1;
  endtask

  task automatic collect(input int base, input logic want_we);
    sel_q.delete();
    for (int i = base; i < log_q.size(); i++)
      if (log_q[i].we == want_we) sel_q.push_back(log_q[i]);
  endtask

  task automatic wait_reads(input int base, input int n, input int budget);
    int k;
    k = 0;
    collect(base, 1'b0);
    while (sel_q.size() < n && k < budget) begin
      tick();
      collect(base, 1'b0);
      k++;
    end
    check("reads_within_budget", 64'(sel_q.size() >= n), 64'd1);
  endtask

  task automatic bus_read(input int a);
    tick();
    bus_cs   = 1'b1;
    bus_we   = 1'b0;
    bus_addr = AW'(a);
    tick();
    bus_idle();
  endtask

  int lb, pb, ib, a, w, busy_start;

  initial begin
    // clean sweep
    reset_init();
    check("reset_scrub_addr", 64'(scrub_addr), 64'd0);
    check("reset_counts", 64'({corr_count, uncorr_count}), 64'd0);
    check("reset_pulses", 64'({uncorr_irq, pass_done, last_uncorr_addr}), 64'd0);
    release_rst();
    lb = log_q.size();
    pb = pass_q.size();
    wait_reads(lb, DEPTH, 220);
    for (int i = 0; i < DEPTH && i < sel_q.size(); i++) begin
      check("sweep_addr", 64'(sel_q[i].addr), 64'(i));
      check("sweep_cyc", 64'(sel_q[i].cyc), 64'(exp_read_cyc(i, -1)));
    end
    repeat (5) tick();
    check("sweep_pass_cnt", 64'(pass_q.size() - pb), 64'd1);
    check("sweep_pass_cyc", 64'((pass_q.size() > pb) ? pass_q[pb] : -1),
          64'(exp_read_cyc(DEPTH - 1, -1) + RL + 1));
    collect(lb, 1'b1);
    check("sweep_no_write", 64'(sel_q.size()), 64'd0);
    check("sweep_counts", 64'({corr_count, uncorr_count}), 64'd0);

    // single-bit error at 5
    reset_init();
    inject(5, 1);
    release_rst();
    lb = log_q.size();
    wait_reads(lb, 7, 150);
    if (sel_q.size() >= 7) begin
      check("single_rd5_cyc", 64'(sel_q[5].cyc), 64'(exp_read_cyc(5, 5)));
      check("single_rd6_cyc", 64'(sel_q[6].cyc), 64'(exp_read_cyc(6, 5)));
    end
    collect(lb, 1'b1);
    check("single_wr_cnt", 64'(sel_q.size()), 64'd1);
    if (sel_q.size() > 0) begin
      check("single_wr_addr", 64'(sel_q[0].addr), 64'd5);
      check("single_wr_data", 64'(sel_q[0].data), 64'(exp_mem[5]));
      check("single_wr_strb", 64'(sel_q[0].strb), 64'hf);
      check("single_wr_cyc", 64'(sel_q[0].cyc),
            64'(exp_read_cyc(5, 5) + RL + 1));
    end
    check("single_corr", 64'(corr_count), 64'd1);
    check("single_uncorr", 64'(uncorr_count), 64'd0);
    bus_read(5);
    check("single_reread_flag", 64'(err_ecc_single), 64'd0);
    check("single_reread_data", 64'(mem_rdata), 64'(exp_mem[5]));

    // double-bit error at 9
    reset_init();
    inject(9, 2);
    release_rst();
    lb = log_q.size();
    ib = irq_q.size();
    wait_reads(lb, 10, 150);
    repeat (5) tick();
    check("double_uncorr", 64'(uncorr_count), 64'd1);
    check("double_last_addr", 64'(last_uncorr_addr), 64'd9);
    check("double_irq_cnt", 64'(irq_q.size() - ib), 64'd1);
    check("double_irq_cyc", 64'((irq_q.size() > ib) ? irq_q[ib] : -1),
          64'(exp_read_cyc(9, -1) + RL + 1));
    collect(lb, 1'b1);
    check("double_no_write", 64'(sel_q.size()), 64'd0);
    check("double_corr", 64'(corr_count), 64'd0);

    // bus contention when the first read is due
    reset_init();
    release_rst();
    lb = log_q.size();
    busy_start = INTERVAL - 1;
    while (cyc < busy_start - 1) tick();
    for (int k = 0; k < 20; k++) begin
      tick();
      bus_cs    = 1'b1;
      bus_we    = 1'($urandom);
      bus_addr  = AW'($urandom);
      bus_wdata = $urandom;
      bus_wstrb = SW'($urandom);
      @(negedge hclk);
      check("contention_mux",
            64'({mem_cs, mem_we, mem_addr, mem_wdata, mem_wstrb}),
            64'({bus_cs, bus_we, bus_addr, bus_wdata, bus_wstrb}));
    end
    tick();
    bus_idle();
    wait_reads(lb, 1, 30);
    if (sel_q.size() > 0) begin
      check("contention_rd_cyc", 64'(sel_q[0].cyc), 64'(busy_start + 20));
      check("contention_rd_addr", 64'(sel_q[0].addr), 64'd0);
    end

    // bus write races the write-back at 3
    reset_init();
    inject(3, 1);
    release_rst();
    lb = log_q.size();
    while (cyc < exp_read_cyc(3, -1) + RL) tick();
    bus_cs    = 1'b1;
    bus_we    = 1'b1;
    bus_addr  = 4'd3;
    bus_wdata = 32'hDEADBEEF;
    bus_wstrb = 4'hf;
    tick();
    bus_idle();
    repeat (4) tick();
    collect(lb, 1'b0);
    check("race_rd3_seen", 64'(sel_q.size() >= 4), 64'd1);
    collect(lb, 1'b1);
    check("race_no_write", 64'(sel_q.size()), 64'd0);
    check("race_corr", 64'(corr_count), 64'd1);
    bus_read(3);
    check("race_data", 64'(mem_rdata), 64'hDEADBEEF);

    // reset while stalled in write-back
    a = $urandom_range(1, 6);
    reset_init();
    inject(a, 1);
    release_rst();
    w = exp_read_cyc(a, -1) + RL + 1;
    while (cyc < w) tick();
    bus_cs   = 1'b1;
    bus_we   = 1'b0;
    bus_addr = AW'($urandom);
    repeat (2) tick();
    @(negedge hclk);
    check("wbrst_pre_corr", 64'(corr_count), 64'd1);
    check("wbrst_pre_addr", 64'(scrub_addr), 64'(a));
    hresetn = 1'b0;
    #1;
    check("wbrst_scrub_addr", 64'(scrub_addr), 64'd0);
    check("wbrst_counts", 64'({corr_count, uncorr_count}), 64'd0);
    check("wbrst_pulses", 64'({uncorr_irq, pass_done, last_uncorr_addr}), 64'd0);
    check("wbrst_mux_bus",
          64'({mem_cs, mem_we, mem_addr, mem_wdata, mem_wstrb}),
          64'({bus_cs, bus_we, bus_addr, bus_wdata, bus_wstrb}));
    bus_idle();
    #1;
    check("wbrst_mux_idle",
          64'({mem_cs, mem_we, mem_addr, mem_wdata, mem_wstrb}), 64'd0);
    release_rst();
    lb = log_q.size();
    wait_reads(lb, 1, 30);
    if (sel_q.size() > 0) begin
      check("wbrst_restart_addr", 64'(sel_q[0].addr), 64'd0);
      check("wbrst_restart_cyc", 64'(sel_q[0].cyc), 64'(INTERVAL));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errs);
    $finish;
  end

endmodule
